// File: rtl/uncache_axi_bridge.sv
// Uncached SRAM-like data port to single-beat AXI4 bridge.
// One request in flight; each request becomes one AR/R or AW/W/B exchange.
module uncache_axi_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // CPU side
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  // AXI read address / data
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       r_data,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AXI write address / data / response
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       w_data,
  output logic [3:0]        w_strb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  // FSM state for checkers and debug
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic                aw_fire;
  logic                w_fire;
  logic                unused_rlast;

  // The single R beat is taken whatever rlast says; arlen is always 0.
  assign unused_rlast = rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both 1; a valid, once raised, holds with stable payload
  // until that edge, and the bridge never waits on ready before raising valid.
  assign addr_ok   = (state_q == S_IDLE) && req;
  assign data_ok   = (state_q == S_RESP);
  assign rdata     = rdata_q;

  assign arvalid   = (state_q == S_AR);
  assign araddr    = addr_q;
  assign arsize    = {1'b0, size_q};
  assign rready    = (state_q == S_R);

  assign awvalid   = (state_q == S_WR) && !aw_done_q;
  assign wvalid    = (state_q == S_WR) && !w_done_q;
  assign awaddr    = addr_q;
  assign awsize    = {1'b0, size_q};
  assign w_data    = wdata_q;
  assign w_strb    = wstrb_q;
  assign wlast     = 1'b1;
  assign bready    = (state_q == S_B);

  assign aw_fire   = awvalid && awready;
  assign w_fire    = wvalid && wready;

  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d    = addr;
          size_d    = size;
          wstrb_d   = wstrb;
          wdata_d   = wdata;
          wr_d      = wr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = wr ? S_WR : S_AR;
        end
      end
      S_AR: begin
        if (arready) begin
          state_d = S_R;
        end
      end
      S_R: begin
        if (rvalid) begin
          rdata_d = r_data;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        // AW and W complete independently; leave once both have happened,
        // which may be in the same cycle.
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (bvalid) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Protocol properties: valids hold with stable payload until accepted.
  a_ar_hold: assert property (@(posedge clk) disable iff (rst)
    arvalid && !arready |=> arvalid && $stable(araddr) && $stable(arsize));
  a_aw_hold: assert property (@(posedge clk) disable iff (rst)
    awvalid && !awready |=> awvalid && $stable(awaddr) && $stable(awsize));
  a_w_hold: assert property (@(posedge clk) disable iff (rst)
    wvalid && !wready |=> wvalid && $stable(w_data) && $stable(w_strb));
  a_data_ok_pulse: assert property (@(posedge clk) disable iff (rst)
    data_ok |=> !data_ok);

endmodule

// File: doc/uncache_axi_bridge.md
Name: uncache_axi_bridge

Overview:
- Responder for the CPU's uncached SRAM-like data port: accepts one request at a time (physical address, wr, size, wstrb, wdata) after kseg1 translation.
- Converts each request into a single-beat AXI4 read or write; returns read data or write completion with a one-cycle data_ok pulse.
- Sits between the MMU/LSU uncached path and the AXI crossbar, in parallel with the dcache.
- arlen/awlen = 0, burst = INCR and fixed IDs are tied at top level and are not ports.

Parameters:
ADDR_W  32  physical address width

Ports:
clk        in   1       core clock
rst        in   1       reset, asynchronous, active-high
req        in   1       CPU request valid
wr         in   1       1 = write, 0 = read
size       in   2       00 byte, 01 half, 10 word
addr       in   ADDR_W  physical address
wstrb      in   4       byte enables (write only)
wdata      in   32      write data
addr_ok    out  1       request accepted this cycle
data_ok    out  1       one-cycle completion pulse
rdata      out  32      read data, valid while data_ok=1
araddr     out  ADDR_W  AXI read address
arsize     out  3       AXI read size
arvalid    out  1       AXI AR valid
arready    in   1       AXI AR ready
r_data     in   32      AXI R data
rlast      in   1       AXI R last
rvalid     in   1       AXI R valid
rready     out  1       AXI R ready
awaddr     out  ADDR_W  AXI write address
awsize     out  3       AXI write size
awvalid    out  1       AXI AW valid
awready    in   1       AXI AW ready
w_data     out  32      AXI W data
w_strb     out  4       AXI W strobe
wlast      out  1       AXI W last, constant 1
wvalid     out  1       AXI W valid
wready     in   1       AXI W ready
bvalid     in   1       AXI B valid
bready     out  1       AXI B ready

Behaviour:
- Reset values (async on rst=1): state IDLE, all AXI valids = 0, data_ok = 0, rdata = 0, captured request regs = 0. Reset mid-transaction abandons it; no data_ok follows.
- FSM states: IDLE, AR, R, WR, B, RESP.
- IDLE:
  - addr_ok = req (combinational; 0 in all other states), so at most one request is outstanding.
  - On req&addr_ok, register addr, size, wstrb, wdata, wr.
  - Next state is WR if wr=1, else AR.
- AR: arvalid=1, araddr=captured addr, arsize={1'b0,size}. Hold until arready, then go to R.
- R: rready=1. On rvalid&rready, register r_data into rdata, then go to RESP. rlast is expected 1; the beat is accepted regardless.
- WR:
  - awvalid and wvalid are asserted together in the first WR cycle.
  - Each valid drops independently after its own handshake (flags aw_done, w_done).
  - Go to B in the cycle both handshakes are complete, including the case where both complete in the same cycle.
  - awsize = {1'b0,size}; w_strb = captured wstrb; w_data = captured wdata; wlast = 1.
- B: bready=1. On bvalid, go to RESP.
- RESP: data_ok=1 for exactly one cycle, then IDLE.
  - For writes, rdata holds its previous value.
  - New requests are not accepted in RESP. Back-to-back requests are spaced by at least one IDLE cycle.
- Response codes: rresp/bresp are not inspected; error responses complete normally.
- Minimum latency, with ready/valid asserted immediately:
  - Read: accept at cycle 0, arvalid at 1, R beat at 2, data_ok at 3.
  - Write: accept at 0, AW+W at 1, B at 2, data_ok at 3.
- AXI stability: AXI outputs are registered or derived only from state and captured regs. Valids never drop before their handshake, and address/data are stable while valid=1.
- Unaligned addr is passed through unchanged. Alignment faults are raised upstream.

Test Plan:
- Read word: req, wr=0, addr=0x1FAF_0000, size=10; arready=1 immediately; rvalid at cycle 2 with r_data=0xDEAD_BEEF → araddr=0x1FAF_0000, arsize=010, data_ok at cycle 3, rdata=0xDEAD_BEEF, addr_ok=0 during cycles 1-3.
- Write byte: addr=0x1FAF_F001, size=00, wstrb=0010, wdata=0x0000_AB00; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 3 cycles, bready asserted only after both handshakes, one data_ok pulse after bvalid.
- Simultaneous AW/W handshake (awready=wready=1) → both valids 1 for exactly one cycle, next state B.
- Back-to-back: a second req held high through a read completion → second request accepted only in the IDLE cycle after data_ok; exactly two data_ok pulses total.
- Async reset asserted during R with rvalid pending → all valids = 0 immediately; state IDLE; no data_ok; a fresh read after reset completes correctly.
- Read with rresp=SLVERR, r_data=0x1234_5678 → completes normally; data_ok=1 with rdata=0x1234_5678.
